// File: rtl/polar_pkg.sv
// polar_pkg: shared types and elaboration helpers for the polar encoder.
//   state_t      - encoder FSM state (LOAD / ENCODE / OUTPUT)
//   popcount()   - number of set bits in a mask
//   bitrev()     - reverse the low w bits of an index
//   info_index() - index of the k-th non-frozen position of a frozen mask
// Masks are passed zero-extended to MAX_N bits so one set of helpers
// serves every codeword length up to MAX_N.
package polar_pkg;

  localparam int MAX_N = 64;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_ENCODE = 2'd1,
    ST_OUTPUT = 2'd2
  } state_t;

  function automatic int unsigned popcount(input logic [MAX_N-1:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < MAX_N; i++)
      if (v[i]) cnt++;
    return cnt;
  endfunction

  function automatic int unsigned bitrev(input int unsigned v, input int unsigned w);
    int unsigned r;
    r = 0;
    for (int b = 0; b < 32; b++)
      if (b < int'(w)) r = (r << 1) | ((v >> b) & 32'd1);
    return r;
  endfunction

  // Position of the k-th (0-based) clear bit of mask, scanning upward.
  function automatic int unsigned info_index(input logic [MAX_N-1:0] mask,
                                             input int unsigned k);
    int unsigned cnt;
    int unsigned idx;
    logic        found;
    cnt   = 0;
    idx   = 0;
    found = 1'b0;
    for (int i = 0; i < MAX_N; i++) begin
      if (!mask[i] && !found) begin
        if (cnt == k) begin
          idx   = unsigned'(i);
          found = 1'b1;
        end
        cnt++;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/polar_encoder_stage.sv
// polar_encoder_stage: one butterfly stage of the polar transform.
//   x      [N-1:0] - current working vector
//   stage  [SW-1:0]- butterfly stage s (0..log2(N)-1)
//   x_nxt  [N-1:0] - x with x[i] ^= x[i + 2^s] for every i whose bit s is clear
// Purely combinational; the top module registers x_nxt once per cycle.
module polar_encoder_stage
  import polar_pkg::*;
#(
  parameter int N  = 8,
  parameter int SW = 2
) (
  input  logic [N-1:0]  x,
  input  logic [SW-1:0] stage,
  output logic [N-1:0]  x_nxt
);

  localparam int LOG2N = $clog2(N);

  // Lane i folds in its partner only when bit s of i is clear; the partner
  // i + 2^s always stays inside the vector because N is a power of two.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic fold;
    always_comb begin
      fold = 1'b0;
      for (int s = 0; s < LOG2N; s++)
        if (stage == SW'(s) && ((i >> s) & 1) == 0)
          fold = x[(i + (1 << s)) % N];
    end
    assign x_nxt[i] = x[i] ^ fold;
  end

endmodule

// File: rtl/polar_encoder.sv
// polar_encoder: serial-in, parallel-out polar encoder.
//   clk, rst_n          - clock, synchronous active-low reset
//   in_valid/in_bit     - info bit stream (ready/valid), ready only in LOAD
//   in_ready            - encoder accepts an info bit this cycle
//   out_valid/out_ready - codeword handshake
//   codeword [N-1:0]    - encoded frame, held until accepted
// Info bits fill the non-frozen positions of u in ascending order; frozen
// positions are forced to zero. The transform runs one butterfly stage per
// cycle in place, then the result is captured into the output register.
// Build option: define POLAR_ENC_BITREV_EN to emit the codeword in
// bit-reversed index order (codeword[i] = x[bitrev(i)]).
module polar_encoder
  import polar_pkg::*;
#(
  parameter int           N           = 8,
  parameter logic [N-1:0] FROZEN_MASK = 8'b0001_0111
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic         in_bit,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] codeword
);

  localparam int               LOG2N    = $clog2(N);
  localparam logic [MAX_N-1:0] MASK_EXT = MAX_N'(FROZEN_MASK);
  localparam int               K        = N - int'(popcount(MASK_EXT));
  localparam int               CNT_W    = (LOG2N < 1) ? 1 : LOG2N;
  localparam int               SW       = $clog2(LOG2N + 1);

  if (K <= 0) begin : g_bad_k
    $error("polar_encoder: FROZEN_MASK leaves no information bits (K == 0)");
  end
  if (N < 2 || N > MAX_N || (1 << LOG2N) != N) begin : g_bad_n
    $error("polar_encoder: N must be a power of two in [2, MAX_N]");
  end

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  bit_cnt;
  logic [SW-1:0]     stg_cnt;
  logic [N-1:0]      x_reg;
  logic [N-1:0]      x_nxt;
  logic [N-1:0]      cw_map;
  logic [N-1:0]      codeword_r;
  logic              out_valid_r;
  logic [LOG2N-1:0]  wr_idx;
  logic              acc;
  logic              last_bit;
  logic              last_stage;
  logic              out_fire;

  assign acc        = in_valid && in_ready;
  assign last_bit   = (bit_cnt == CNT_W'(K - 1));
  assign last_stage = (stg_cnt == SW'(LOG2N - 1));
  assign out_fire   = out_valid_r && out_ready;
  assign wr_idx     = LOG2N'(info_index(MASK_EXT, 32'(bit_cnt)));

  polar_encoder_stage #(.N(N), .SW(SW)) u_stage (
    .x     (x_reg),
    .stage (stg_cnt),
    .x_nxt (x_nxt)
  );

`ifdef POLAR_ENC_BITREV_EN
  for (genvar i = 0; i < N; i++) begin : g_map
    assign cw_map[i] = x_reg[LOG2N'(bitrev(i, LOG2N))];
  end
`else
  assign cw_map = x_reg;
`endif

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_LOAD;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD:   if (acc && last_bit) state_nxt = ST_ENCODE;
      ST_ENCODE: if (last_stage)      state_nxt = ST_OUTPUT;
      ST_OUTPUT: if (out_fire)        state_nxt = ST_LOAD;
      default:                        state_nxt = ST_LOAD;
    endcase
  end

  // FSM: outputs. in_ready is also gated by rst_n so it reads 0 while
  // reset is held, before the first edge has cleared the state.
  always_comb begin
    in_ready = rst_n && (state == ST_LOAD);
  end

  // Datapath. The first OUTPUT cycle captures the finished vector into the
  // codeword register; out_valid rises with it, one cycle after the final
  // butterfly, and nothing in the register moves until the handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt     <= '0;
      stg_cnt     <= '0;
      x_reg       <= '0;
      codeword_r  <= '0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          stg_cnt <= '0;
          if (acc) begin
            x_reg[wr_idx] <= in_bit;
            bit_cnt       <= last_bit ? '0 : bit_cnt + CNT_W'(1);
          end
        end
        ST_ENCODE: begin
          x_reg   <= x_nxt;
          stg_cnt <= last_stage ? '0 : stg_cnt + SW'(1);
        end
        ST_OUTPUT: begin
          if (!out_valid_r) begin
            codeword_r  <= cw_map;
            out_valid_r <= 1'b1;
          end else if (out_ready) begin
            out_valid_r <= 1'b0;
            // Clearing here keeps frozen positions zero for the next frame.
            x_reg       <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = out_valid_r;
  assign codeword  = codeword_r;

endmodule

// File: tb/tb_polar_encoder.sv
// Testbench for polar_encoder (N=8, FROZEN_MASK=8'b0001_0111, info 3,5,6,7).
module tb_polar_encoder;

  localparam int          N      = 8;
  localparam int          K      = 4;
  localparam logic [7:0]  FROZEN = 8'b0001_0111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_bit;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] codeword;

  int n_pass  = 0;
  int n_total = 0;

  polar_encoder #(.N(N), .FROZEN_MASK(FROZEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .codeword  (codeword)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] info;   // info[0] is sent first
    logic [7:0] exp;
    int         stall;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference: place info bits on the non-frozen positions, then
  // x[i] = XOR of u[j] over every j that contains all bits of i.
  function automatic logic [7:0] ref_cw(input logic [3:0] info);
    logic [7:0] u;
    logic [7:0] x;
    logic [7:0] r;
    int         k;
    int         ri;
    k = 0;
    for (int j = 0; j < N; j++) begin
      if (FROZEN[j]) u[j] = 1'b0;
      else begin
        u[j] = info[k];
        k++;
      end
    end
    for (int i = 0; i < N; i++) begin
      x[i] = 1'b0;
      for (int j = 0; j < N; j++)
        if ((j & i) == i) x[i] = x[i] ^ u[j];
    end
    for (int i = 0; i < N; i++) begin
`ifdef POLAR_ENC_BITREV_EN
      ri = ((i & 1) << 2) | (i & 2) | ((i >> 2) & 1);
`else
      ri = i;
`endif
      r[i] = x[ri];
    end
    return r;
  endfunction

  // Starts and ends on a falling edge; in_valid is dropped after the last
  // accept, so the caller sits in the cycle following the K-th accept edge.
  task automatic send_frame(input logic [3:0] info);
    for (int k = 0; k < K; k++) begin
      in_valid = 1'b1;
      in_bit   = info[k];
      chk("in_ready_load", in_ready, 1);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  // Waits for the codeword, checks latency and value, holds out_ready low
  // for 'stall' cycles while poking in_valid, then completes the handshake.
  task automatic get_frame(input logic [7:0] exp, input int stall);
    int         cnt;
    logic [7:0] held;
    cnt = 0;
    chk("in_ready_encode", in_ready, 0);
    while (!out_valid && cnt < 40) begin
      out_ready = 1'($urandom_range(0, 1));  // must not matter before valid
      @(posedge clk);
      cnt++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("latency", cnt, 4);
    chk("codeword", codeword, exp);
    held = codeword;
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_bit   = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_codeword", codeword, held);
      chk("stall_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_hs_valid", out_valid, 0);
    chk("post_hs_in_ready", in_ready, 1);
  endtask

  task automatic do_reset(input int cycles);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready_held", in_ready, 0);
    end
    chk("rst_out_valid", out_valid, 0);
    chk("rst_codeword", codeword, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t       vecs[5];
    logic [3:0] info;
    logic [7:0] model_cw;
    int         quiet;

`ifdef POLAR_ENC_BITREV_EN
    vecs[0] = '{info: 4'b0001, exp: 8'h55, stall: 0};
`else
    vecs[0] = '{info: 4'b0001, exp: 8'h0F, stall: 0};
`endif
    vecs[1] = '{info: 4'b1000, exp: 8'hFF, stall: 0};
    vecs[2] = '{info: 4'b0010, exp: 8'h33, stall: 5};
    vecs[3] = '{info: 4'b0000, exp: 8'h00, stall: 1};
    vecs[4] = '{info: 4'b1111, exp: 8'h96, stall: 2};

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_bit = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    do_reset(2);
    @(negedge clk);

    // Known vectors, back to back (next frame starts right after handshake).
    for (int i = 0; i < 5; i++) begin
      send_frame(vecs[i].info);
      get_frame(vecs[i].exp, vecs[i].stall);
    end

    // Abort a frame after two accepted bits; no codeword may appear for it.
    in_valid = 1'b1;
    in_bit   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    do_reset(2);
    quiet = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (!out_valid) quiet++;
    end
    chk("abort_no_output", quiet, 6);
    send_frame(4'b1000);
    get_frame(8'hFF, 0);

    // Randomised frames against the reference model.
    for (int f = 0; f < 16; f++) begin
      info     = 4'($urandom_range(0, 15));
      model_cw = ref_cw(info);
      send_frame(info);
      get_frame(model_cw, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/polar_encoder.md
POLAR_ENCODER -- requirements
Module: polar_encoder

Interface
REQ-001 SHALL have parameter N, default 8, meaning codeword length (power of two, >= 2).
REQ-002 SHALL have parameter FROZEN_MASK, default 8'b0001_0111, meaning N-bit mask where bit i = 1 marks u[i] frozen to 0.
REQ-003 SHALL derive localparams LOG2N = clog2(N) and K = N - popcount(FROZEN_MASK), and SHALL raise an elaboration error if K == 0.
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1, meaning an info bit is offered.
REQ-007 SHALL have port in_bit, input, 1, meaning the info bit value.
REQ-008 SHALL have port in_ready, output, 1, meaning the encoder accepts an info bit this cycle.
REQ-009 SHALL have port out_valid, output, 1, meaning the codeword is valid.
REQ-010 SHALL have port out_ready, input, 1, meaning the sink accepts the codeword.
REQ-011 SHALL have port codeword, output, N, carrying codeword bits x[N-1:0].

Function
REQ-012 SHALL run FSM states LOAD, ENCODE, OUTPUT.
REQ-013 In LOAD, in_ready = 1; each in_valid&&in_ready transfer writes in_bit to the next non-frozen index of u, in ascending index order.
REQ-014 Frozen u positions SHALL be 0 in every frame, independent of previous frames.
REQ-015 On the K-th accepted bit, LOAD SHALL transition to ENCODE on the next edge; stage counter = 0.
REQ-016 ENCODE SHALL perform one butterfly stage per cycle: for stage s, for every i with bit s of i clear, x[i] <= x[i] ^ x[i + 2^s]; s runs 0..LOG2N-1.
REQ-017 The result SHALL equal x[i] = XOR of u[j] over all j with (j & i) == i.
REQ-018 After LOG2N ENCODE cycles, the FSM SHALL enter OUTPUT; out_valid SHALL rise exactly LOG2N+1 cycles after the edge accepting the K-th bit.
REQ-019 In OUTPUT, out_valid = 1 and codeword SHALL hold stable until out_valid&&out_ready.
REQ-020 After the handshake, the FSM SHALL return to LOAD on the next edge; in_ready SHALL be 0 throughout ENCODE and OUTPUT.
REQ-021 in_valid asserted outside LOAD SHALL be ignored, with no state change.
REQ-022 An out_ready asserted before out_valid SHALL have no effect.

Reset
REQ-023 While rst_n = 0 at a clock edge: FSM = LOAD, bit counter = 0, stage counter = 0, u/x register = 0, out_valid = 0, codeword = 0.
REQ-024 in_ready SHALL be 0 while rst_n = 0 and 1 in the first cycle after release.
REQ-025 Reset asserted mid-frame (any state) SHALL discard the partial frame; no codeword is emitted for it.

Configuration
REQ-026 Macro POLAR_ENC_BITREV_EN SHALL control output ordering.
REQ-027 With POLAR_ENC_BITREV_EN defined, codeword[i] SHALL equal x[bitrev_LOG2N(i)]; latency and handshake are unchanged.
REQ-028 With POLAR_ENC_BITREV_EN undefined, codeword[i] SHALL equal x[i] (natural order).

Structure
REQ-029 Shared package polar_pkg SHALL hold the FSM state enum typedef plus functions bitrev(), popcount(), and info_index(mask, k) returning the k-th non-frozen index.
REQ-030 Sub-module polar_encoder_stage (combinational, inputs x[N] and stage index, output next x[N]) SHALL implement REQ-016 and is instantiated once.

Verification (N=8, FROZEN_MASK=8'b0001_0111, info indices 3,5,6,7)
REQ-031 Info bits 1,0,0,0 -> codeword 8'h0F, out_valid 4 cycles after the last accept; with BITREV_EN -> 8'h55.
REQ-032 Info bits 0,0,0,1 -> codeword 8'hFF; info bits 0,1,0,0 -> 8'h33.
REQ-033 out_ready held 0 for 5 cycles in OUTPUT -> codeword and out_valid stable; in_ready = 0; in_valid pulses ignored.
REQ-034 Back-to-back frames 1,0,0,0 then 0,0,0,1 with out_ready = 1 -> 8'h0F then 8'hFF, with no frozen-bit leakage between frames.
REQ-035 rst_n pulled low after 2 accepted bits, then frame 0,0,0,1 sent -> single codeword 8'hFF; no output for the aborted frame.
